// File: rtl/fpadd_pipe_if.sv
// Handshake bus for the pipelined FP add/sub unit: operand issue side and
// result/flag writeback side.
interface fpadd_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] reg_A;
    logic [W-1:0] reg_B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_ovf;
    logic         flag_unf;
    logic         flag_inv;

    modport master (
        output in_valid, op_sub, reg_A, reg_B, out_ready,
        input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
    );

    modport slave (
        input  in_valid, op_sub, reg_A, reg_B, out_ready,
        output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
    );
endinterface

// File: rtl/fpadd_pipe.sv
// Fully pipelined floating-point add/subtract with round-to-nearest-even,
// special-value handling and exception flags. Operands are registered on
// acceptance, then pass through align (S1), add/normalise (S2) and
// round/pack (S3); the whole pipe stalls as one when the consumer backs up.
module fpadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic          clk,
    input logic          reset,
    fpadd_pipe_if.slave  bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int AW   = MAN_W + 4;           // hidden + mantissa + G/R/S
    localparam int XW   = EXP_W + 2;           // signed working exponent
    localparam int LZ_W = $clog2(MAN_W + 5);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    logic advance;

    // input capture
    logic         v0, sub0;
    logic [W-1:0] a0, b0;

    // S1 combinational
    logic             sa, sb, za, zb, ia, ib, na, nb, a_big, s_big, z_small;
    logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
    logic [MAN_W-1:0] fa, fb, f_big, f_small;
    logic [W-2:0]     mag_a, mag_b;
    logic [MAN_W:0]   m_small;
    logic [2*AW-1:0]  wide, sh;
    logic [AW-1:0]    al_small;
    special_t         sp_c;
    logic             sgn_c, inv_c;

    // S1 registers
    logic             v1, sub1, sgn1, inv1;
    special_t         sp1;
    logic [EXP_W-1:0] e1;
    logic [AW-1:0]    mb1, ms1;

    // S2 combinational
    logic [AW:0]      sum;
    logic [LZ_W-1:0]  lz;
    logic [AW-1:0]    norm_c;
    logic [XW-1:0]    x_c;

    // S2 registers
    logic                 v2, sgn2, inv2;
    special_t             sp2;
    logic signed [XW-1:0] x2;
    logic [AW-1:0]        n2;

    // S3 combinational
    logic                 up, ovf_c, unf_c;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] xr;
    logic [W-1:0]         res_c;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = reset || advance;

    // S1: unpack, classify, order by magnitude, align the smaller operand, decide specials
    always_comb begin
        sa = a0[W-1];
        sb = b0[W-1] ^ sub0;
        ea = a0[W-2:MAN_W];
        eb = b0[W-2:MAN_W];
        fa = a0[MAN_W-1:0];
        fb = b0[MAN_W-1:0];
        za = (ea == '0);
        zb = (eb == '0);
        ia = (ea == '1) && (fa == '0);
        ib = (eb == '1) && (fb == '0);
        na = (ea == '1) && (fa != '0);
        nb = (eb == '1) && (fb != '0);
        // denormals collapse to zero before the magnitude compare
        mag_a = za ? '0 : a0[W-2:0];
        mag_b = zb ? '0 : b0[W-2:0];
        a_big   = (mag_a >= mag_b);
        s_big   = a_big ? sa : sb;
        e_big   = a_big ? mag_a[W-2:MAN_W] : mag_b[W-2:MAN_W];
        e_small = a_big ? mag_b[W-2:MAN_W] : mag_a[W-2:MAN_W];
        f_big   = a_big ? fa : fb;
        f_small = a_big ? fb : fa;
        z_small = a_big ? zb : za;
        m_small = z_small ? '0 : {1'b1, f_small};
        d       = e_big - e_small;
        wide    = {m_small, 3'b000, {AW{1'b0}}};
        sh      = wide >> d;
        if (32'(d) >= 32'(MAN_W + 3)) begin
            al_small = {{(AW-1){1'b0}}, |m_small};
        end else begin
            al_small = {sh[2*AW-1:AW+1], sh[AW] | (|sh[AW-1:0])};
        end

        sp_c  = SP_NONE;
        sgn_c = s_big;
        inv_c = 1'b0;
        if (na || nb || (ia && ib && (sa != sb))) begin
            sp_c  = SP_NAN;
            sgn_c = 1'b0;
            inv_c = 1'b1;
        end else if (ia || ib) begin
            sp_c  = SP_INF;
            sgn_c = ia ? sa : sb;
        end else if (za && zb) begin
            sp_c  = SP_ZERO;
            sgn_c = sa && sb;
        end else if ((mag_a == mag_b) && (sa != sb)) begin
            sp_c  = SP_ZERO;
            sgn_c = 1'b0;
        end
    end

    // S2: mantissa add/subtract, then normalise with exponent adjust
    always_comb begin
        sum = sub1 ? ({1'b0, mb1} - {1'b0, ms1}) : ({1'b0, mb1} + {1'b0, ms1});
        lz  = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (sum[i]) lz = LZ_W'(AW - 1 - i);
        end
        if (sum[AW]) begin
            norm_c = {sum[AW:2], sum[1] | sum[0]};
            x_c    = {2'b00, e1} + XW'(1);
        end else begin
            norm_c = sum[AW-1:0] << lz;
            x_c    = {2'b00, e1} - XW'(lz);
        end
    end

    // S3: round to nearest even, range check, pack
    always_comb begin
        up    = n2[2] && (n2[1] || n2[0] || n2[3]);
        mr    = {1'b0, n2[AW-1:3]} + (MAN_W+2)'(up);
        frac  = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        xr    = mr[MAN_W+1] ? (x2 + XW'(1)) : x2;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        res_c = '0;
        case (sp2)
            SP_NAN:  res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            SP_INF:  res_c = {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: res_c = {sgn2, {(W-1){1'b0}}};
            default: begin
                if (xr >= EMAX) begin
                    res_c = {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_c = 1'b1;
                end else if (xr[XW-1] || (xr == '0)) begin
                    res_c = {sgn2, {(W-1){1'b0}}};
                    unf_c = 1'b1;
                end else begin
                    res_c = {sgn2, xr[EXP_W-1:0], frac};
                end
            end
        endcase
    end

    // valid chain and output register; the whole pipe moves only on advance
    always_ff @(posedge clk) begin
        if (reset) begin
            v0            <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flag_ovf  <= 1'b0;
            bus.flag_unf  <= 1'b0;
            bus.flag_inv  <= 1'b0;
        end else if (advance) begin
            v0            <= bus.in_valid;
            v1            <= v0;
            v2            <= v1;
            bus.out_valid <= v2;
            bus.result    <= res_c;
            bus.flag_ovf  <= ovf_c;
            bus.flag_unf  <= unf_c;
            bus.flag_inv  <= inv2;
        end
    end

    // datapath stage registers; contents are don't-care behind a cleared valid
    always_ff @(posedge clk) begin
        if (advance) begin
            a0   <= bus.reg_A;
            b0   <= bus.reg_B;
            sub0 <= bus.op_sub;
            sub1 <= (sa != sb);
            sgn1 <= sgn_c;
            inv1 <= inv_c;
            sp1  <= sp_c;
            e1   <= e_big;
            mb1  <= {1'b1, f_big, 3'b000};
            ms1  <= al_small;
            sgn2 <= sgn1;
            inv2 <= inv1;
            sp2  <= sp1;
            x2   <= x_c;
            n2   <= norm_c;
        end
    end
endmodule

// File: doc/fpadd_pipe.md
# fpadd_pipe

Parametrised, fully pipelined floating-point add/subtract unit with valid/ready handshakes. It replaces the fixed single-precision `fpadd_mult` datapath in the FP arithmetic chain and accepts one operation per cycle. Format width, subtract mode, round-to-nearest-even, special-value handling and exception flags are built in. It sits between the operand-issue logic and the result writeback, and supports backpressure from the consumer.

## Interface
Parameters:
- `EXP_W`, default 8: exponent field width (minimum 4).
- `MAN_W`, default 23: stored mantissa width, hidden bit excluded (minimum 4).
- `W` (localparam) = 1 + `EXP_W` + `MAN_W`: total operand width.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair present on the input.
- `in_ready`  out  1  the unit accepts the input this cycle.
- `op_sub`  in  1  1 computes `reg_A` − `reg_B`; 0 computes `reg_A` + `reg_B`.
- `reg_A`  in  W  operand A, {sign, exp, man}.
- `reg_B`  in  W  operand B, same format.
- `out_valid`  out  1  `result` and the flags are valid.
- `out_ready`  in  1  the consumer takes the result this cycle.
- `result`  out  W  sum or difference.
- `flag_ovf`  out  1  result overflowed to infinity.
- `flag_unf`  out  1  nonzero result was flushed to zero.
- `flag_inv`  out  1  invalid operation, or a NaN input.

## Operation
- When `op_sub` = 1, flip the sign of B, then perform a single signed add.
- Denormal inputs (exp = 0) are treated as signed zero. Denormals are never produced.
- Pipeline stages:
  - S1: unpack, classify (zero/inf/NaN/normal), compare magnitudes, swap so that |A| ≥ |B|, right-align the smaller operand keeping guard, round and sticky bits. If the shift is ≥ MAN_W+3, all shifted-out bits go to sticky.
  - S2: add or subtract the mantissas (MAN_W+5 bits). Normalise: on carry-out, shift right by 1 with sticky kept; otherwise shift left by the leading-zero count, with the exponent adjusted in EXP_W+2 signed bits.
  - S3: round to nearest even (round up when G & (R | S | lsb)). If rounding carries out, shift right and increment the exponent. Then pack.
- Special cases are decided in S1 and carried down as a 2-bit override:
  - Any NaN input, or +inf + −inf: canonical quiet NaN {0, all-ones, 1, 0…}; `flag_inv` = 1.
  - Inf with a finite operand: that infinity.
  - Exact cancellation (x − x): +0.
  - Zero + zero: sign is the AND of both signs.
- Overflow (exponent after rounding ≥ 2^EXP_W − 1): ±inf, `flag_ovf` = 1.
- Underflow (exponent ≤ 0 with a nonzero mantissa): signed zero, `flag_unf` = 1.

## Timing
- Latency: 3 cycles. An operation accepted at edge N presents `out_valid` = 1 after edge N+3 when there is no stall.
- Throughput: one operation per cycle.
- Stall rule: `advance` = !`out_valid` | `out_ready`, and `in_ready` = `advance`.
  - All stage registers, including the valid bits, load only when `advance` = 1.
  - When `advance` = 0, every stage holds and no bubble is collapsed.
- A transfer occurs only when valid and ready are both high. The input side must not be read without `in_ready`.
- While `out_valid` = 1 and `out_ready` = 0, `result` and the flags hold stable.
- Results leave in issue order. No operation is dropped or duplicated.
- Flags are aligned with `result` and valid only when `out_valid` = 1.
- Reset:
  - All stage valid bits are cleared on the edge where `reset` = 1. Outputs read `out_valid` = 0, `result` = 0 and all flags = 0 from the next cycle.
  - During reset, `in_ready` = 1.
  - Reset mid-stream discards every in-flight operation. Inputs presented while `reset` = 1 are ignored.
- `in_valid` = 0 inserts a bubble, which propagates with valid = 0. Datapath registers may hold any value during a bubble.

## Test plan
- Basic add and throughput: default widths, `reg_A` = 3F800000 + 40000000 → `result` = 40400000, `out_valid` 3 cycles after acceptance. Back-to-back 40400000 − 3F800000 (`op_sub`) → 40000000 on the next cycle.
- Cancellation: `op_sub` = 1, 3F800000 − 3F800000 → 00000000.
- Exceptions:
  - 7F7FFFFF + 7F7FFFFF → 7F800000, `flag_ovf` = 1.
  - 7F800000 − 7F800000 → 7FC00000, `flag_inv` = 1.
  - 00800000 − 00800001 → 80000000, `flag_unf` = 1.
- Rounding:
  - 3F800000 + 33800000 → 3F800000 (tie, rounds to even).
  - 3F800001 + 33800000 → 3F800002.
  - 3F800000 + 33800001 → 3F800001.
- Backpressure:
  - Issue 6 consecutive operations while holding `out_ready` low for 5 cycles. `in_ready` must drop once the pipeline is full, `result` must stay stable, and all 6 results must arrive in order with no loss.
  - Then assert `reset` with 2 operations in flight: `out_valid` = 0 on the following cycle, and no stale result appears afterwards.
- Half precision: `EXP_W` = 5, `MAN_W` = 10.
  - 3C00 + 3C00 → 4000.
  - 7BFF + 7BFF → 7C00, `flag_ovf` = 1.
